// File: rtl/lcd_pixel_packer.sv
// Pairs UART bytes into RGB565 pixels (high byte first), tags frame/line position
// for the panel, and queues them in a show-ahead FIFO behind a valid/ready port.
//
// state | meaning
// S_HI  | waiting for the high byte of the next pixel
// S_LO  | high byte latched, waiting for the low byte (timeout armed)
module lcd_pixel_packer #(
  parameter int DEPTH        = 16,
  parameter int H_ACTIVE     = 240,
  parameter int V_ACTIVE     = 135,
  parameter int BYTE_TIMEOUT = 27000
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  input  logic                     frame_restart,
  output logic [15:0]              pix_data,
  output logic                     pix_valid,
  input  logic                     pix_ready,
  output logic                     pix_sof,
  output logic                     pix_eol,
  output logic                     pix_eof,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     timeout_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(H_ACTIVE);
  localparam int RW = $clog2(V_ACTIVE);
  localparam int TW = $clog2(BYTE_TIMEOUT);

  localparam logic [0:0] S_HI = 1'b0;
  localparam logic [0:0] S_LO = 1'b1;

  logic [0:0]    r_state;
  logic [7:0]    r_hi;
  logic [TW-1:0] r_tmo_cnt;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [18:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_overflow;
  logic          r_timeout_err;

  logic          w_pix_done;
  logic          w_rd;
  logic          w_wr;
  logic          w_full;
  logic          w_sof;
  logic          w_eol;
  logic          w_eof;
  logic [18:0]   w_head;

  assign w_pix_done = !frame_restart && (r_state == S_LO) && rx_valid;
  assign pix_valid  = (r_level != '0);
  assign w_rd       = !frame_restart && pix_valid && pix_ready;
  assign w_full     = (r_level == LW'(DEPTH));
  // A full FIFO still takes the write when the head leaves in the same cycle.
  assign w_wr       = w_pix_done && (!w_full || w_rd);

  assign w_sof = (r_col == '0) && (r_row == '0);
  assign w_eol = (r_col == CW'(H_ACTIVE - 1));
  assign w_eof = w_eol && (r_row == RW'(V_ACTIVE - 1));

  // Timeout is a down-counter loaded at the high byte; expiry at zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= S_HI;
      r_hi          <= '0;
      r_tmo_cnt     <= '0;
      r_timeout_err <= 1'b0;
    end else if (frame_restart) begin
      r_state       <= S_HI;
      r_tmo_cnt     <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        S_HI: begin
          if (rx_valid) begin
            r_hi      <= rx_data;
            r_tmo_cnt <= TW'(BYTE_TIMEOUT - 1);
            r_state   <= S_LO;
          end
        end
        S_LO: begin
          if (rx_valid) begin
            r_state <= S_HI;
          end else if (r_tmo_cnt == '0) begin
            r_timeout_err <= 1'b1;
            r_state       <= S_HI;
          end else begin
            r_tmo_cnt <= r_tmo_cnt - TW'(1);
          end
        end
        default: r_state <= S_HI;
      endcase
    end
  end

  // Position advances on dropped pixels too, keeping alignment with the host.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_col <= '0;
      r_row <= '0;
    end else if (frame_restart) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_pix_done) begin
      if (w_eol) begin
        r_col <= '0;
        r_row <= (r_row == RW'(V_ACTIVE - 1)) ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else if (frame_restart) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_pix_done && !w_wr) r_overflow <= 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= {w_eof, w_eol, w_sof, r_hi, rx_data};
  end

  assign w_head = r_mem[r_rd_ptr];
  assign {pix_eof, pix_eol, pix_sof, pix_data} = pix_valid ? w_head : 19'd0;

  assign level       = r_level;
  assign overflow    = r_overflow;
  assign timeout_err = r_timeout_err;

endmodule
